// File: rtl/clk_period_meter_pkg.sv
// Shared types and defaults for clk_period_meter: FSM state encoding,
// counter width / timeout defaults and the averaging window depth.
package clk_period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

  localparam int          CNT_W_DEF       = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 32'd65535;
  localparam int          AVG_DEPTH       = 4;

endpackage

// File: rtl/clk_period_meter_sync.sv
// sync_rise_det: 2-FF synchronizer plus history flop; reports the
// synchronized level and a single-cycle rising-edge strobe.
module sync_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign lvl_o  = s2_q;
  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous clock-like input in clk cycles.
// Optional 4-sample averaging of reports when PERIOD_AVG4_EN is defined.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             meas_ok,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);

  state_e           st_q, st_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d;
  logic [CNT_W-1:0] per_q, per_d, hi_q, hi_d;
  logic             vld_q, vld_d, ok_q, ok_d, tmo_q, tmo_d;
  logic             rise, s2;
  logic             meas_end, tmo_hit;
  logic             rep_ok;
  logic [CNT_W-1:0] rep_per, rep_hi;

  sync_rise_det u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (sig_in),
    .lvl_o  (s2),
    .rise_o (rise)
  );

  // A rise in the timeout cycle still completes the measurement.
  assign meas_end = ena && (st_q == MEASURE) && rise;
  assign tmo_hit  = ena && (st_q == MEASURE) && !rise && (pcnt_q == TO_LIM);

`ifdef PERIOD_AVG4_EN
  localparam int SUM_W = CNT_W + 2;

  logic [AVG_DEPTH-2:0][CNT_W-1:0] aper_q, ahi_q;
  logic [1:0]                      afill_q;
  logic                            avg_clr;
  logic [SUM_W-1:0]                psum, hsum;

  assign avg_clr = !ena || (st_q == IDLE) || tmo_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aper_q  <= '0;
      ahi_q   <= '0;
      afill_q <= '0;
    end else if (avg_clr) begin
      aper_q  <= '0;
      ahi_q   <= '0;
      afill_q <= '0;
    end else if (meas_end) begin
      aper_q <= {aper_q[AVG_DEPTH-3:0], pcnt_q};
      ahi_q  <= {ahi_q[AVG_DEPTH-3:0], hcnt_q};
      if (afill_q != 2'(AVG_DEPTH-1)) afill_q <= afill_q + 2'd1;
    end
  end

  always_comb begin
    psum = SUM_W'(pcnt_q);
    hsum = SUM_W'(hcnt_q);
    for (int i = 0; i < AVG_DEPTH-1; i++) begin
      psum = psum + SUM_W'(aper_q[i]);
      hsum = hsum + SUM_W'(ahi_q[i]);
    end
  end

  assign rep_ok  = (afill_q == 2'(AVG_DEPTH-1));
  assign rep_per = psum[SUM_W-1:2];
  assign rep_hi  = hsum[SUM_W-1:2];
`else
  assign rep_ok  = 1'b1;
  assign rep_per = pcnt_q;
  assign rep_hi  = hcnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (!ena) st_d = IDLE;
    else begin
      case (st_q)
        IDLE:    st_d = ARMED;
        ARMED:   if (rise) st_d = MEASURE;
        MEASURE: if (tmo_hit) st_d = TIMEOUT;
        TIMEOUT: if (rise) st_d = MEASURE;
        default: st_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pcnt_d = pcnt_q;
    hcnt_d = hcnt_q;
    per_d  = per_q;
    hi_d   = hi_q;
    vld_d  = 1'b0;
    ok_d   = ok_q;
    tmo_d  = tmo_q;
    if (!ena) begin
      pcnt_d = '0;
      hcnt_d = '0;
      ok_d   = 1'b0;
      tmo_d  = 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          pcnt_d = '0;
          hcnt_d = '0;
          ok_d   = 1'b0;
        end
        ARMED, TIMEOUT: begin
          // First rise only opens a window; nothing to report yet.
          if (rise) begin
            pcnt_d = CNT_W'(1);
            hcnt_d = CNT_W'(1);
            tmo_d  = 1'b0;
          end
        end
        MEASURE: begin
          if (rise) begin
            if (rep_ok) begin
              per_d = rep_per;
              hi_d  = rep_hi;
              vld_d = 1'b1;
              ok_d  = 1'b1;
            end
            pcnt_d = CNT_W'(1);
            hcnt_d = CNT_W'(1);
          end else if (tmo_hit) begin
            tmo_d = 1'b1;
            ok_d  = 1'b0;
          end else begin
            pcnt_d = pcnt_q + CNT_W'(1);
            hcnt_d = hcnt_q + CNT_W'(s2);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      hcnt_q <= '0;
      per_q  <= '0;
      hi_q   <= '0;
      vld_q  <= 1'b0;
      ok_q   <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      hcnt_q <= hcnt_d;
      per_q  <= per_d;
      hi_q   <= hi_d;
      vld_q  <= vld_d;
      ok_q   <= ok_d;
      tmo_q  <= tmo_d;
    end
  end

  assign period_out = per_q;
  assign high_out   = hi_q;
  assign meas_valid = vld_q;
  assign meas_ok    = ok_q;
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter (TIMEOUT_CYC=100); expected values hand-derived.
module tb_clk_period_meter;

  localparam int CW = 16;
  localparam int TO = 100;
`ifdef PERIOD_AVG4_EN
  localparam int DISC = 4;
`else
  localparam int DISC = 2;
`endif

  logic          clk = 1'b0, rst_n = 1'b1, ena = 1'b0, sig_in = 1'b0;
  logic [CW-1:0] period_out, high_out;
  logic          meas_valid, meas_ok, timeout;

  int total = 0, bad = 0;
  int nvld = 0, cyc = 0, lastcyc = 0, prevcyc = 0;
  logic [CW-1:0] lastp = '0, lasth = '0;
  bit wave_en = 1'b0, man_val = 1'b0;
  int per_len = 8, hi_len = 4, ph = 0;
  int n0;
  int gaps[5] = '{8, 8, 12, 12, 16};

  always #5 clk = ~clk;

  clk_period_meter #(.CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sig_in(sig_in),
    .period_out(period_out), .high_out(high_out),
    .meas_valid(meas_valid), .meas_ok(meas_ok), .timeout(timeout)
  );

  // Report monitor and sig_in driver, both on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (meas_valid) begin
      nvld++;
      prevcyc = lastcyc;
      lastcyc = cyc;
      lastp   = period_out;
      lasth   = high_out;
    end
    if (wave_en) begin
      sig_in = (ph < hi_len);
      ph = (ph + 1 >= per_len) ? 0 : ph + 1;
    end else begin
      sig_in = man_val;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_vld(input string tag, input int budget);
    int start, k;
    start = nvld;
    k = 0;
    while (nvld == start && k < budget) begin
      tick(1);
      k++;
    end
    if (nvld == start) chk({tag, "_expired"}, 0, 1);
  endtask

  task automatic set_wave(input int p, input int h);
    per_len = p;
    hi_len  = h;
    ph      = 0;
    wave_en = 1'b1;
  endtask

  task automatic steady(input string tag, input int p, input int h, input int nrep);
    for (int i = 0; i < DISC; i++) wait_vld({tag, "_disc"}, 4 * p + 20);
    for (int i = 0; i < nrep; i++) begin
      wait_vld(tag, 2 * p + 10);
      chk({tag, "_per"}, 32'(lastp), p);
      chk({tag, "_high"}, 32'(lasth), h);
      chk({tag, "_ok"}, 32'(meas_ok), 1);
      chk({tag, "_gap"}, lastcyc - prevcyc, p);
      chk({tag, "_pulse"}, 32'(meas_valid), 0);
    end
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #2;
    chk("rst_per", 32'(period_out), 0);
    chk("rst_high", 32'(high_out), 0);
    chk("rst_vld", 32'(meas_valid), 0);
    chk("rst_ok", 32'(meas_ok), 0);
    chk("rst_tmo", 32'(timeout), 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    ena = 1'b1;

    set_wave(8, 4);
    steady("w8", 8, 4, 3);
    chk("w8_tmo", 32'(timeout), 0);

    set_wave(10, 3);
    steady("w10", 10, 3, 2);

    set_wave(2, 1);
    steady("w2", 2, 1, 2);

    // Hold low: pcnt runs into the limit.
    wave_en = 1'b0;
    man_val = 1'b0;
    tick(150);
    chk("to_flag", 32'(timeout), 1);
    chk("to_ok", 32'(meas_ok), 0);
    chk("to_per", 32'(period_out), 2);
    chk("to_high", 32'(high_out), 1);

    // Rise from TIMEOUT clears the flag, then a lone rise times out 100 cycles later.
    n0 = nvld;
    man_val = 1'b1;
    tick(3);
    chk("to_clr", 32'(timeout), 0);
    man_val = 1'b0;
    tick(99);
    chk("to_early", 32'(timeout), 0);
    tick(1);
    chk("to_edge", 32'(timeout), 1);
    chk("to_norep", nvld - n0, 0);
    chk("to_per2", 32'(period_out), 2);

    // Restart from TIMEOUT: first rise discarded, first report is a full period.
    n0 = nvld;
    set_wave(8, 4);
    wait_vld("rearm", 120);
    chk("rearm_per", 32'(lastp), 8);
    chk("rearm_high", 32'(lasth), 4);
    chk("rearm_cnt", nvld - n0, 1);
    chk("rearm_tmo", 32'(timeout), 0);

    // Mid-measurement reset.
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("mrst_per", 32'(period_out), 0);
    chk("mrst_high", 32'(high_out), 0);
    chk("mrst_vld", 32'(meas_valid), 0);
    chk("mrst_ok", 32'(meas_ok), 0);
    chk("mrst_tmo", 32'(timeout), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_vld("mrst_first", 120);
    chk("mrst_rep_per", 32'(lastp), 8);
    chk("mrst_rep_high", 32'(lasth), 4);

    // ena dropped for 3 cycles.
    tick(3);
    ena = 1'b0;
    n0 = nvld;
    tick(1);
    chk("ena_ok", 32'(meas_ok), 0);
    chk("ena_per", 32'(period_out), 8);
    chk("ena_high", 32'(high_out), 4);
    tick(2);
    ena = 1'b1;
    chk("ena_novld", nvld - n0, 0);
    wait_vld("ena_first", 120);
    chk("ena_rep_per", 32'(lastp), 8);
    chk("ena_rep_high", 32'(lasth), 4);

    // Rises exactly TIMEOUT_CYC apart: rise wins over timeout.
    set_wave(100, 50);
    steady("w100", 100, 50, 1);
    chk("w100_tmo", 32'(timeout), 0);

    // Hand-placed rises: raw periods 8,8,12,12,16, each with 2 high cycles.
    wave_en = 1'b0;
    man_val = 1'b0;
    ena = 1'b0;
    tick(2);
    ena = 1'b1;
    tick(4);
    n0 = nvld;
    for (int i = 0; i < 6; i++) begin
      man_val = 1'b1;
      tick(2);
      man_val = 1'b0;
      if (i < 5) tick(gaps[i] - 2);
      if (i == 4) begin
`ifdef PERIOD_AVG4_EN
        chk("seq4_cnt", nvld - n0, 1);
        chk("seq4_per", 32'(lastp), 10);
`else
        chk("seq4_cnt", nvld - n0, 4);
        chk("seq4_per", 32'(lastp), 12);
`endif
        chk("seq4_high", 32'(lasth), 2);
      end
    end
    tick(6);
`ifdef PERIOD_AVG4_EN
    chk("seq5_cnt", nvld - n0, 2);
    chk("seq5_per", 32'(lastp), 12);
`else
    chk("seq5_cnt", nvld - n0, 5);
    chk("seq5_per", 32'(lastp), 16);
`endif
    chk("seq5_high", 32'(lasth), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
